metro_scroll_ctrl: RTL and testbench

Sequencer for the Metro multiplexed seven-segment display. Drives the glyph index into the existing glyph decoder (indices 0–18) and the active-low digit anodes. Steps a DIGITS-wide window across the MSG_LEN-glyph message at a fixed scroll rate and time-multiplexes the digits at a refresh rate. Sits between the top-level start/stop controls and the decoder/anode pins.

---
 rtl/metro_scroll_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_metro_scroll_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/metro_scroll_ctrl.sv
// Scrolling-window sequencer for the Metro multiplexed seven-segment display.
// Define SCROLL_PAUSE_EN to hold the message at position 0 for HOLD_STEPS scroll periods per wrap.
module metro_scroll_ctrl #(
    parameter int unsigned MSG_LEN     = 19,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned SCROLL_DIV  = 50000000,
    parameter int unsigned HOLD_STEPS  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    output logic [10:0]       o_glyph_idx,
    output logic [DIGITS-1:0] o_an,
    output logic [4:0]        o_pos,
    output logic              o_busy,
    output logic              o_wrap
);

    localparam int unsigned RefW  = $clog2(REFRESH_DIV);
    localparam int unsigned ScrW  = $clog2(SCROLL_DIV);
    localparam int unsigned DigW  = $clog2(DIGITS);
    localparam int unsigned HoldW = $clog2(HOLD_STEPS) + 1;

    localparam logic [RefW-1:0]  RefLast  = RefW'(REFRESH_DIV - 1);
    localparam logic [ScrW-1:0]  ScrLast  = ScrW'(SCROLL_DIV - 1);
    localparam logic [DigW-1:0]  DigLast  = DigW'(DIGITS - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_STEPS - 1);
    localparam logic [4:0]       PosLast  = 5'(MSG_LEN - 1);
    localparam logic [10:0]      MsgLen11 = 11'(MSG_LEN);

    // StHold is only ever entered when the pause feature is compiled in.
    typedef enum logic [1:0] {StIdle, StScroll, StHold} state_e;

    state_e            r_state;
    state_e            w_state_next;

    logic [RefW-1:0]   r_ref_cnt;
    logic [RefW-1:0]   w_ref_cnt_next;
    logic [DigW-1:0]   r_digit;
    logic [DigW-1:0]   w_digit_next;
    logic [ScrW-1:0]   r_scr_cnt;
    logic [ScrW-1:0]   w_scr_cnt_next;
    logic [HoldW-1:0]  r_hold_cnt;
    logic [HoldW-1:0]  w_hold_cnt_next;
    logic [4:0]        r_pos;
    logic [4:0]        w_pos_next;
    logic [10:0]       r_glyph;
    logic [10:0]       w_glyph_next;
    logic [10:0]       w_sum;
    logic [DIGITS-1:0] r_an;
    logic [DIGITS-1:0] w_an_next;
    logic              r_wrap;
    logic              w_wrap_next;

    logic              w_ref_tc;
    logic              w_scr_tc;
    logic              w_go;
    logic              w_step;
    logic              w_hold_done;

    assign w_ref_tc    = (r_ref_cnt == RefLast);
    assign w_scr_tc    = (r_scr_cnt == ScrLast);
    assign w_go        = i_start && !i_stop && (r_state == StIdle);
    assign w_step      = (r_state == StScroll) && w_scr_tc && !i_stop;
    assign w_hold_done = (r_state == StHold) && w_scr_tc && (r_hold_cnt == HoldLast) && !i_stop;

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state; stop has priority over everything else
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_go) begin
                    w_state_next = StScroll;
                end
            end
            StScroll: begin
                if (i_stop) begin
                    w_state_next = StIdle;
                end
`ifdef SCROLL_PAUSE_EN
                else if (w_step && (r_pos == PosLast)) begin
                    w_state_next = StHold;
                end
`endif
            end
            StHold: begin
                if (i_stop) begin
                    w_state_next = StIdle;
                end else if (w_hold_done) begin
                    w_state_next = StScroll;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_busy = (r_state != StIdle);
    end

    // Refresh runs in every state and is never disturbed by start/stop.
    always_comb begin
        w_ref_cnt_next = w_ref_tc ? '0 : r_ref_cnt + 1'b1;
        w_digit_next   = r_digit;
        if (w_ref_tc) begin
            w_digit_next = (r_digit == DigLast) ? '0 : r_digit + 1'b1;
        end
    end

    always_comb begin
        w_scr_cnt_next  = '0;
        w_hold_cnt_next = '0;
        w_pos_next      = '0;
        w_wrap_next     = 1'b0;
        if (!i_stop && (r_state != StIdle)) begin
            w_scr_cnt_next = w_scr_tc ? '0 : r_scr_cnt + 1'b1;
            w_pos_next     = r_pos;
            if (r_state == StHold) begin
                if (w_hold_done) begin
                    w_hold_cnt_next = '0;
                end else if (w_scr_tc) begin
                    w_hold_cnt_next = r_hold_cnt + 1'b1;
                end else begin
                    w_hold_cnt_next = r_hold_cnt;
                end
            end else if (w_step) begin
                if (r_pos == PosLast) begin
                    w_pos_next  = '0;
                    w_wrap_next = 1'b1;
                end else begin
                    w_pos_next = r_pos + 1'b1;
                end
            end
        end
    end

    // Glyph and anode are both derived from next-state values so they land on the same edge.
    // pos + digit is at most 2*MSG_LEN-2, so one conditional subtract reduces it.
    always_comb begin
        w_sum        = 11'(w_pos_next) + 11'(w_digit_next);
        w_glyph_next = '0;
        if (w_state_next != StIdle) begin
            w_glyph_next = (w_sum >= MsgLen11) ? (w_sum - MsgLen11) : w_sum;
        end
        w_an_next = ~(DIGITS'(1) << w_digit_next);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ref_cnt  <= '0;
            r_digit    <= '0;
            r_scr_cnt  <= '0;
            r_hold_cnt <= '0;
            r_pos      <= '0;
            r_glyph    <= '0;
            r_an       <= ~DIGITS'(1);
            r_wrap     <= 1'b0;
        end else begin
            r_ref_cnt  <= w_ref_cnt_next;
            r_digit    <= w_digit_next;
            r_scr_cnt  <= w_scr_cnt_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_pos      <= w_pos_next;
            r_glyph    <= w_glyph_next;
            r_an       <= w_an_next;
            r_wrap     <= w_wrap_next;
        end
    end

    assign o_glyph_idx = r_glyph;
    assign o_an        = r_an;
    assign o_pos       = r_pos;
    assign o_wrap      = r_wrap;

endmodule

// File: tb/tb_metro_scroll_ctrl.sv
// Self-checking bench for metro_scroll_ctrl; honours SCROLL_PAUSE_EN like the design.
// Expected outputs come from closed-form functions of cycles-since-reset and cycles-since-start.
module tb_metro_scroll_ctrl;

    localparam int MsgLen    = 19;
    localparam int Digits    = 4;
    localparam int RefDiv    = 4;
    localparam int ScrDiv    = 8;
    localparam int HoldSteps = 2;
`ifdef SCROLL_PAUSE_EN
    localparam bit PauseEn = 1'b1;
`else
    localparam bit PauseEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [10:0]       glyph_idx;
    logic [Digits-1:0] an;
    logic [4:0]        pos;
    logic              busy;
    logic              wrap;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles since reset release, busy flag, cycles since busy rose.
    int m_cyc = 0;
    bit m_busy = 1'b0;
    int m_k = 0;

    logic [Digits-1:0] exp_an;
    logic [10:0]       exp_glyph;
    logic [4:0]        exp_pos;
    logic              exp_busy;
    logic              exp_wrap;

    always #5 clk = ~clk;

    metro_scroll_ctrl #(
        .MSG_LEN    (MsgLen),
        .DIGITS     (Digits),
        .REFRESH_DIV(RefDiv),
        .SCROLL_DIV (ScrDiv),
        .HOLD_STEPS (HoldSteps)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_stop     (stop),
        .o_glyph_idx(glyph_idx),
        .o_an       (an),
        .o_pos      (pos),
        .o_busy     (busy),
        .o_wrap     (wrap)
    );

    // Advance one clock, update the model with the inputs seen at that edge, clear pulses.
    task automatic step();
        int period;
        int p;
        int d;
        @(posedge clk);
        if (!rst_n) begin
            m_cyc  = 0;
            m_busy = 1'b0;
            m_k    = 0;
        end else begin
            m_cyc++;
            if (stop) begin
                m_busy = 1'b0;
            end else if (start && !m_busy) begin
                m_busy = 1'b1;
                m_k    = 0;
            end else if (m_busy) begin
                m_k++;
            end
        end
        period    = PauseEn ? (MsgLen + HoldSteps) : MsgLen;
        p         = (m_k / ScrDiv) % period;
        d         = (m_cyc / RefDiv) % Digits;
        exp_busy  = m_busy;
        exp_pos   = (m_busy && p < MsgLen) ? 5'(p) : 5'd0;
        exp_wrap  = m_busy && (m_k > 0) && (m_k % ScrDiv == 0) && (p == (PauseEn ? MsgLen : 0));
        exp_an    = ~(Digits'(1) << d);
        exp_glyph = m_busy ? 11'((int'(exp_pos) + d) % MsgLen) : 11'd0;
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (an !== 4'b1110) begin
            errors++;
            $display("FAIL reset_an: got %b want %b", an, 4'b1110);
        end
        checks++;
        if (glyph_idx !== 11'd0) begin
            errors++;
            $display("FAIL reset_glyph: got %0d want 0", glyph_idx);
        end
        checks++;
        if (pos !== 5'd0 || busy !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: pos=%0d busy=%b wrap=%b want 0 0 0", pos, busy, wrap);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_refresh();
        logic [Digits-1:0] seq [4];
        int idx;
        int dwell;
        seq[0] = 4'b1110;
        seq[1] = 4'b1101;
        seq[2] = 4'b1011;
        seq[3] = 4'b0111;
        for (int i = 1; i <= 20; i++) begin
            step();
            idx   = (i / RefDiv) % Digits;
            dwell = i % RefDiv;
            checks++;
            if (an !== seq[idx]) begin
                errors++;
                $display("FAIL idle_an c%0d: got %b want %b (dwell %0d)", i, an, seq[idx], dwell);
            end
            checks++;
            if (glyph_idx !== 11'd0 || busy !== 1'b0 || pos !== 5'd0) begin
                errors++;
                $display("FAIL idle_out c%0d: glyph=%0d busy=%b pos=%0d want 0 0 0",
                         i, glyph_idx, busy, pos);
            end
        end
    endtask

    task automatic test_start_scroll();
        repeat ($urandom_range(0, 5)) step();
        start = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: got %b want 1", busy);
        end
        for (int i = 0; i < 24; i++) begin
            step();
            if (i == 7) begin
                checks++;
                if (pos !== 5'd1) begin
                    errors++;
                    $display("FAIL first_step_pos: got %0d want 1", pos);
                end
            end
            if (pos == 5'd1 && an == 4'b1011) begin
                checks++;
                if (glyph_idx !== 11'd3) begin
                    errors++;
                    $display("FAIL pos1_digit2: got %0d want 3", glyph_idx);
                end
            end
            checks++;
            if (an !== exp_an || glyph_idx !== exp_glyph || pos !== exp_pos ||
                busy !== exp_busy || wrap !== exp_wrap) begin
                errors++;
                $display("FAIL scroll t=%0t: an=%b/%b glyph=%0d/%0d pos=%0d/%0d busy=%b/%b wrap=%b/%b",
                         $time, an, exp_an, glyph_idx, exp_glyph, pos, exp_pos, busy, exp_busy,
                         wrap, exp_wrap);
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        int wrap_at;
        int pos1_at;
        int wraps;
        n = 0;
        while (pos != 5'd18 && n < 200) begin
            step();
            n++;
            checks++;
            if (an !== exp_an || glyph_idx !== exp_glyph || pos !== exp_pos ||
                busy !== exp_busy || wrap !== exp_wrap) begin
                errors++;
                $display("FAIL to_wrap t=%0t: an=%b/%b glyph=%0d/%0d pos=%0d/%0d busy=%b/%b wrap=%b/%b",
                         $time, an, exp_an, glyph_idx, exp_glyph, pos, exp_pos, busy, exp_busy,
                         wrap, exp_wrap);
            end
        end
        checks++;
        if (pos !== 5'd18) begin
            errors++;
            $display("FAIL reach_pos18: timed out with pos=%0d want 18", pos);
        end
        wrap_at = -1;
        pos1_at = -1;
        wraps   = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (pos == 5'd18 && an == 4'b1101) begin
                checks++;
                if (glyph_idx !== 11'd0) begin
                    errors++;
                    $display("FAIL pos18_digit1: got %0d want 0", glyph_idx);
                end
            end
            if (pos == 5'd18 && an == 4'b0111) begin
                checks++;
                if (glyph_idx !== 11'd2) begin
                    errors++;
                    $display("FAIL pos18_digit3: got %0d want 2", glyph_idx);
                end
            end
            if (wrap === 1'b1) begin
                wraps++;
                wrap_at = i;
            end
            if (wrap_at >= 0 && pos1_at < 0 && pos == 5'd1) begin
                pos1_at = i;
            end
            checks++;
            if (an !== exp_an || glyph_idx !== exp_glyph || pos !== exp_pos ||
                busy !== exp_busy || wrap !== exp_wrap) begin
                errors++;
                $display("FAIL wrap t=%0t: an=%b/%b glyph=%0d/%0d pos=%0d/%0d busy=%b/%b wrap=%b/%b",
                         $time, an, exp_an, glyph_idx, exp_glyph, pos, exp_pos, busy, exp_busy,
                         wrap, exp_wrap);
            end
        end
        checks++;
        if (wraps != 1) begin
            errors++;
            $display("FAIL wrap_pulses: got %0d want 1", wraps);
        end
        checks++;
        if (pos1_at < 0 || (pos1_at - wrap_at) != (PauseEn ? 24 : 8)) begin
            errors++;
            $display("FAIL wrap_to_pos1: got %0d cycles want %0d", pos1_at - wrap_at,
                     PauseEn ? 24 : 8);
        end
    endtask

    task automatic test_stop();
        int n;
        n = 0;
        while (pos != 5'd5 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (pos !== 5'd5) begin
            errors++;
            $display("FAIL reach_pos5: timed out with pos=%0d want 5", pos);
        end
        stop = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || pos !== 5'd0 || glyph_idx !== 11'd0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL stop: busy=%b pos=%0d glyph=%0d wrap=%b want 0 0 0 0",
                     busy, pos, glyph_idx, wrap);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (glyph_idx !== 11'd0 || an !== exp_an) begin
                errors++;
                $display("FAIL stopped_digits: glyph=%0d an=%b want 0 %b", glyph_idx, an, exp_an);
            end
        end
        start = 1'b1;
        stop  = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_same: busy got %b want 0", busy);
        end
    endtask

    task automatic test_stop_on_tc();
        int n;
        start = 1'b1;
        step();
        repeat (ScrDiv * $urandom_range(1, 3)) step();
        n = 0;
        while (m_k % ScrDiv != ScrDiv - 1 && n < 20) begin
            step();
            n++;
        end
        stop = 1'b1;
        step();
        checks++;
        if (wrap !== 1'b0 || pos !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_on_tc: wrap=%b pos=%0d busy=%b want 0 0 0", wrap, pos, busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        start = 1'b1;
        step();
        n = 0;
        while (pos != 5'd7 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (pos !== 5'd7) begin
            errors++;
            $display("FAIL reach_pos7: timed out with pos=%0d want 7", pos);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (an !== 4'b1110 || glyph_idx !== 11'd0 || pos !== 5'd0 || busy !== 1'b0 ||
            wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: an=%b glyph=%0d pos=%0d busy=%b wrap=%b want 1110 0 0 0 0",
                     an, glyph_idx, pos, busy, wrap);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 199) == 0);
            rst_n = ($urandom_range(0, 399) != 0);
            step();
            rst_n = 1'b1;
            checks++;
            if (an !== exp_an || glyph_idx !== exp_glyph || pos !== exp_pos ||
                busy !== exp_busy || wrap !== exp_wrap) begin
                errors++;
                $display("FAIL random t=%0t: an=%b/%b glyph=%0d/%0d pos=%0d/%0d busy=%b/%b wrap=%b/%b",
                         $time, an, exp_an, glyph_idx, exp_glyph, pos, exp_pos, busy, exp_busy,
                         wrap, exp_wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_refresh();
        test_start_scroll();
        test_wrap();
        test_stop();
        test_stop_on_tc();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
